// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit driving a single-port word-wide data memory
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended, little-endian.
module lsu_mem_ctrl #(
  parameter int MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RSP  = 2'b11
  } state_e;

  localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        req_err;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept = req_valid & ready_q & (state_q == S_IDLE);

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_addr[31:2] >= DEPTH_W) begin
      req_err = 1'b1;
    end
  end

  // Lane positions come from the captured address; mem_rdata is valid during RD.
  assign byte_sh = mem_rdata >> {lane_q, 3'b000};
  assign half_sh = mem_rdata >> {lane_q[1], 4'b0000};

  always_comb begin
    ld_data = mem_rdata;
    st_word = mem_rdata;
    case (size_q)
      2'b00: begin
        ld_data = {{24{~uns_q & byte_sh[7]}}, byte_sh[7:0]};
        st_word = (mem_rdata & ~(32'h0000_00FF << {lane_q, 3'b000}))
                | ({24'h0, wdata_q[7:0]} << {lane_q, 3'b000});
      end
      2'b01: begin
        ld_data = {{16{~uns_q & half_sh[15]}}, half_sh[15:0]};
        st_word = (mem_rdata & ~(32'h0000_FFFF << {lane_q[1], 4'b0000}))
                | ({16'h0, wdata_q[15:0]} << {lane_q[1], 4'b0000});
      end
      default: begin
        ld_data = mem_rdata;
        st_word = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d        = req_we;
          size_d      = req_size;
          uns_d       = req_unsigned;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = req_err;
          if (req_err) begin
            state_d = S_RSP;
          end else begin
            mem_addr_d = {2'b00, req_addr[31:2]};
            if (req_we && (req_size == 2'b10)) begin
              mem_wen_d   = 1'b1;
              mem_wdata_d = req_wdata;
              state_d     = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          mem_wen_d   = 1'b1;
          mem_wdata_d = st_word;
          state_d     = S_WR;
        end else begin
          rsp_rdata_d = ld_data;
          state_d     = S_RSP;
        end
      end
      S_WR: begin
        mem_wen_d   = 1'b0;
        mem_wdata_d = 32'h0;
        rsp_rdata_d = 32'h0;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered ready keeps req_ready low through reset and the first edge after it.
  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed-vector bench for lsu_mem_ctrl with a behavioural word memory
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:31];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_DEPTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_wen && (mem_addr < 32'd32)) mem[mem_addr[4:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // One request/response; latency counts edges from the accept edge (inclusive) to rsp_valid.
  task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_wen, input logic [31:0] exp_idx);
    int t;
    int lat;
    int wen_cnt;
    logic [31:0] wen_idx;
    lat = 0; wen_cnt = 0; wen_idx = 32'h0;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_wen) begin
        wen_cnt++;
        wen_idx = mem_addr;
      end
      if (rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_wen_cnt"}, 32'(wen_cnt), 32'(exp_wen));
    if (exp_wen != 0) chk({tag, "_wen_idx"}, wen_idx, exp_idx);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    pl_en = 1'b0; pl_idx = 5'd0; pl_val = 32'h0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

    // word store then word load
    run("t1_st", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 0, 2, 32'h0, 1'b0, 1, 32'd2);
    chk("t1_mem2", mem[2], 32'hDEADBEEF);
    run("t1_ld", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 2, 32'hDEADBEEF, 1'b0, 0, 32'd0);

    // byte store RMW, half store to upper lane
    preload(5'd1, 32'h11223344);
    run("t2_sb", 1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AA, 0, 3, 32'h0, 1'b0, 1, 32'd1);
    chk("t2_mem1", mem[1], 32'h11AA3344);
    preload(5'd3, 32'h55667788);
    run("t2_sh", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234CAFE, 0, 3, 32'h0, 1'b0, 1, 32'd3);
    chk("t2_mem3", mem[3], 32'hCAFE7788);

    // sign/zero extension
    preload(5'd0, 32'h8000F080);
    run("t3_lb", 1'b0, 2'b00, 1'b0, 32'h00, 32'h0, 0, 2, 32'hFFFFFF80, 1'b0, 0, 32'd0);
    run("t3_lhu", 1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 0, 2, 32'h00008000, 1'b0, 0, 32'd0);
    run("t3_lh", 1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 0, 2, 32'hFFFFF080, 1'b0, 0, 32'd0);
    run("t3_lbu3", 1'b0, 2'b00, 1'b1, 32'h03, 32'h0, 0, 2, 32'h00000080, 1'b0, 0, 32'd0);

    // last valid index, then error cases
    preload(5'd31, 32'hA5A50001);
    run("t4_last", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 0, 2, 32'hA5A50001, 1'b0, 0, 32'd0);
    run("t4_mis_w", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, 1, 32'h0, 1'b1, 0, 32'd0);
    run("t4_mis_h", 1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF, 0, 1, 32'h0, 1'b1, 0, 32'd0);
    run("t4_size3", 1'b1, 2'b11, 1'b0, 32'h00, 32'h1, 0, 1, 32'h0, 1'b1, 0, 32'd0);
    run("t4_range", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 0, 1, 32'h0, 1'b1, 0, 32'd0);
    chk("t4_mem0_intact", mem[0], 32'h8000F080);

    // backpressure on response
    run("t5_hold", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5, 2, 32'hDEADBEEF, 1'b0, 0, 32'd0);
    chk("t5_ready_after", 32'(req_ready), 32'd1);
    run("t5_next", 1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 0, 2, 32'h00000011, 1'b0, 0, 32'd0);

    // reset during WR of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h05; req_wdata = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_wen_pre", 32'(mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_wen", 32'(mem_wen), 32'd0);
    chk("t6_wdata", mem_wdata, 32'h0);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rsp_rdata", rsp_rdata, 32'h0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("t6_ready_after_edge", 32'(req_ready), 32'd1);
    chk("t6_mem1_intact", mem[1], 32'h11AA3344);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
